linebuf_sched: RTL and testbench
================================

LINEBUF_SCHED -- requirements
Module: linebuf_sched

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 11, the line-buffer address width; one address per pixel column.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port vsync, input, 1 bit: active-high frame start.
REQ-005 The module SHALL have port hsync, input, 1 bit: active-high line start.
REQ-006 The module SHALL have port de, input, 1 bit: pixel valid, one pixel per cycle.
REQ-007 The module SHALL have port rd_addr, output, ADDR_W bits: read address to all three line buffers.
REQ-008 The module SHALL have port wr_addr, output, ADDR_W bits: write address, equal to rd_addr delayed one cycle.
REQ-009 The module SHALL have port wr_en, output, 1 bit: write strobe, equal to the accepted-pixel flag delayed one cycle.
REQ-010 The module SHALL have port wr_sel, output, 3 bits: one-hot select of the line buffer being written.
REQ-011 The module SHALL have port top_sel, output, 3 bits: one-hot select of the oldest line buffer, wr_sel rotated left by 1.
REQ-012 The module SHALL have port mid_sel, output, 3 bits: one-hot select of the previous line buffer, wr_sel rotated left by 2.
REQ-013 The module SHALL have port win_valid, output, 1 bit: a full 3x3 window is available, aligned with wr_en.
REQ-014 The module SHALL have port border, output, 1 bit: border flag, aligned with wr_en; see Configuration.

Function
REQ-015 The FSM SHALL have states IDLE, FILL and RUN; IDLE->FILL on vsync; FILL->RUN when the completed-line count reaches 2; RUN holds until vsync, which returns it to FILL.
REQ-016 Input priority SHALL be vsync > hsync > de; a lower-priority input asserted in the same cycle SHALL be ignored.
REQ-017 On vsync: col<=0, line count<=0, wr_sel<=3'b001, pixel accept=0.
REQ-018 On hsync (vsync low): col<=0; if col!=0, wr_sel SHALL rotate left by 1 and line count SHALL increment, saturating at 2; hsync with col==0 SHALL cause no rotation.
REQ-019 On de (vsync and hsync low, state FILL or RUN): the pixel SHALL be accepted and col SHALL increment modulo 2^ADDR_W; de in IDLE SHALL be ignored.
REQ-020 rd_addr SHALL equal col; wr_addr and wr_en SHALL lag rd_addr and accept by exactly 1 cycle, giving read-before-write.
REQ-021 win_valid SHALL be 1 one cycle after an accepted pixel for which state==RUN and col>=2; otherwise 0.
REQ-022 top_sel, mid_sel and wr_sel SHALL always be mutually exclusive and one-hot.

Reset
REQ-023 While rst_n=0: state=IDLE, col=0, line count=0, rd_addr=0, wr_addr=0, wr_en=0, wr_sel=3'b001, win_valid=0, border=0.
REQ-024 Reset assertion mid-line SHALL take effect immediately, without a clock edge; after release the block SHALL wait in IDLE for vsync.

Configuration
REQ-025 Macro LINEBUF_SCHED_BORDER_EN, when defined: border SHALL be 1 one cycle after an accepted pixel with col<2 or line count<2, otherwise 0.
REQ-026 Macro LINEBUF_SCHED_BORDER_EN, when undefined: border SHALL be constant 0, with no border logic synthesised; all other behaviour SHALL be identical.

Verification
REQ-027 Reset mid-line, then release -> all outputs at REQ-023 values; de before vsync -> wr_en stays 0.
REQ-028 vsync, then 3 lines of 8 de pixels with hsync between lines -> wr_sel goes 001, 010, 100; win_valid=0 on lines 0-1; on line 2 win_valid=1 for cols 2..7, i.e. 6 cycles.
REQ-029 de every cycle, col 0..5 -> wr_addr=rd_addr-1 each cycle and wr_en=1 one cycle after de.
REQ-030 hsync and de in the same cycle -> pixel dropped and col=0; two consecutive hsyncs -> single rotation.
REQ-031 ADDR_W=3, 9 de pixels -> rd_addr wraps from 7 to 0.
REQ-032 With LINEBUF_SCHED_BORDER_EN defined, frame of 4 lines x 4 pixels -> border=1 for all pixels of lines 0-1 and cols 0-1; border=0 for cols 2-3 of lines 2-3. Undefined -> border always 0.

Source files
------------

// File: rtl/linebuf_sched_if.sv
// Video timing inputs and line-buffer control outputs of the 3-line window scheduler.
// master = timing source / buffer array side, slave = scheduler side.
interface linebuf_sched_if #(
  parameter int ADDR_W = 11
);
  logic              vsync;
  logic              hsync;
  logic              de;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic [2:0]        wr_sel;
  logic [2:0]        top_sel;
  logic [2:0]        mid_sel;
  logic              win_valid;
  logic              border;

  modport master (
    output vsync, hsync, de,
    input  rd_addr, wr_addr, wr_en, wr_sel, top_sel, mid_sel, win_valid, border
  );

  modport slave (
    input  vsync, hsync, de,
    output rd_addr, wr_addr, wr_en, wr_sel, top_sel, mid_sel, win_valid, border
  );
endinterface

// File: rtl/linebuf_sched.sv
// 3-line buffer scheduler for 3x3 windows; LINEBUF_SCHED_BORDER_EN adds the border flag.
// Read addr combinational from col, writes/flags one cycle later; no backpressure, one pixel per de.
module linebuf_sched #(
  parameter int ADDR_W = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  linebuf_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  localparam logic [ADDR_W-1:0] COL_TWO = ADDR_W'(2);

  state_t            state;
  logic [ADDR_W-1:0] col;
  logic [1:0]        line_cnt;
  logic [2:0]        sel;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              wr_en_q;
  logic              win_valid_q;
  logic              accept;

  // vsync and hsync both pre-empt a same-cycle pixel
  assign accept = bus.de && !bus.vsync && !bus.hsync && (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      col         <= '0;
      line_cnt    <= 2'd0;
      sel         <= 3'b001;
      wr_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      win_valid_q <= 1'b0;
    end else begin
      wr_addr_q   <= col;
      wr_en_q     <= accept;
      win_valid_q <= accept && (state == RUN) && (col >= COL_TWO);
      if (bus.vsync) begin
        state    <= FILL;
        col      <= '0;
        line_cnt <= 2'd0;
        sel      <= 3'b001;
      end else if (bus.hsync) begin
        col <= '0;
        // an empty line (repeated hsync) does not advance the buffers
        if (col != '0) begin
          sel <= {sel[1:0], sel[2]};
          if (line_cnt != 2'd2) line_cnt <= line_cnt + 2'd1;
          if (state == FILL && line_cnt == 2'd1) state <= RUN;
        end
      end else if (accept) begin
        col <= col + ADDR_W'(1);
      end
    end
  end

`ifdef LINEBUF_SCHED_BORDER_EN
  logic border_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) border_q <= 1'b0;
    else        border_q <= accept && ((col < COL_TWO) || (line_cnt < 2'd2));
  end

  assign bus.border = border_q;
`else
  assign bus.border = 1'b0;
`endif

  assign bus.rd_addr   = col;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_sel    = sel;
  assign bus.top_sel   = {sel[1:0], sel[2]};
  assign bus.mid_sel   = {sel[0], sel[2:1]};
  assign bus.win_valid = win_valid_q;

endmodule

// File: tb/tb_linebuf_sched.sv
// Directed bench for linebuf_sched with a scoreboard of expected write-side results.
module tb_linebuf_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  linebuf_sched_if #(.ADDR_W(11)) bus ();
  linebuf_sched_if #(.ADDR_W(3))  bus3 ();

  assign bus3.vsync = bus.vsync;
  assign bus3.hsync = bus.hsync;
  assign bus3.de    = bus.de;

  linebuf_sched #(.ADDR_W(11)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  linebuf_sched #(.ADDR_W(3))  dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  typedef struct packed {
    logic [10:0] addr;
    logic        win;
    logic        bd;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;
  int win_cnt;
  int bd_cnt;

  // reference model: 0=IDLE 1=FILL 2=RUN
  int          m_state;
  logic [10:0] m_col;
  logic [10:0] m_prev;
  logic [2:0]  m_col3;
  int          m_lcnt;
  logic [2:0]  m_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_col   = '0;
    m_prev  = '0;
    m_col3  = '0;
    m_lcnt  = 0;
    m_sel   = 3'b001;
    sb.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd_addr"},   bus.rd_addr,   0);
    chk({tag, "_wr_addr"},   bus.wr_addr,   0);
    chk({tag, "_wr_en"},     bus.wr_en,     0);
    chk({tag, "_wr_sel"},    bus.wr_sel,    3'b001);
    chk({tag, "_top_sel"},   bus.top_sel,   3'b010);
    chk({tag, "_mid_sel"},   bus.mid_sel,   3'b100);
    chk({tag, "_win_valid"}, bus.win_valid, 0);
    chk({tag, "_border"},    bus.border,    0);
    chk({tag, "_rd_addr3"},  bus3.rd_addr,  0);
  endtask

  // drive one cycle of inputs, advance the model, then check after the edge
  task automatic step(input logic v, input logic h, input logic d);
    logic acc;
    exp_t e;
    exp_t got;
    bus.vsync = v;
    bus.hsync = h;
    bus.de    = d;
    acc = d && !v && !h && (m_state != 0);
    if (acc) begin
      e.addr = m_col;
      e.win  = (m_state == 2) && (m_col >= 11'd2);
`ifdef LINEBUF_SCHED_BORDER_EN
      e.bd   = (m_col < 11'd2) || (m_lcnt < 2);
`else
      e.bd   = 1'b0;
`endif
      sb.push_back(e);
    end
    m_prev = m_col;
    if (v) begin
      m_state = 1;
      m_col   = '0;
      m_col3  = '0;
      m_lcnt  = 0;
      m_sel   = 3'b001;
    end else if (h) begin
      if (m_col != 11'd0) begin
        m_sel = {m_sel[1:0], m_sel[2]};
        if (m_lcnt < 2) m_lcnt++;
        if (m_state == 1 && m_lcnt == 2) m_state = 2;
      end
      m_col  = '0;
      m_col3 = '0;
    end else if (acc) begin
      m_col  = m_col + 11'd1;
      m_col3 = m_col3 + 3'd1;
    end
    @(posedge clk);
    #1;
    chk("wr_en",    bus.wr_en,    acc);
    chk("rd_addr",  bus.rd_addr,  m_col);
    chk("wr_addr",  bus.wr_addr,  m_prev);
    chk("wr_sel",   bus.wr_sel,   m_sel);
    chk("top_sel",  bus.top_sel,  {m_sel[1:0], m_sel[2]});
    chk("mid_sel",  bus.mid_sel,  {m_sel[0], m_sel[2:1]});
    chk("rd_addr3", bus3.rd_addr, m_col3);
    if (bus.wr_en === 1'b1) begin
      chk("sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        got = sb.pop_front();
        chk("sb_wr_addr",   bus.wr_addr,   got.addr);
        chk("sb_win_valid", bus.win_valid, got.win);
        chk("sb_border",    bus.border,    got.bd);
      end
    end else begin
      chk("win_idle",    bus.win_valid, 0);
      chk("border_idle", bus.border,    0);
    end
    if (bus.win_valid === 1'b1) win_cnt++;
    if (bus.border === 1'b1)    bd_cnt++;
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.vsync = 1'b0;
    bus.hsync = 1'b0;
    bus.de    = 1'b0;
    win_cnt   = 0;
    bd_cnt    = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst0");
    rst_n = 1'b1;

    // start a frame, then pull reset mid-line without a clock edge
    step(1'b1, 1'b0, 1'b0);
    pixels(3);
    bus.de = 1'b1;
    rst_n  = 1'b0;
    #2;
    chk_reset("rst_mid");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // pixels before vsync are ignored
    pixels(3);
    chk("idle_rd_addr", bus.rd_addr, 0);

    // three lines of eight pixels
    step(1'b1, 1'b0, 1'b0);
    win_cnt = 0;
    pixels(8);
    step(1'b0, 1'b1, 1'b0);
    chk("sel_line1", bus.wr_sel, 3'b010);
    pixels(8);
    chk("win_lines01", win_cnt, 0);
    step(1'b0, 1'b1, 1'b0);
    chk("sel_line2", bus.wr_sel, 3'b100);
    win_cnt = 0;
    pixels(8);
    step(1'b0, 1'b0, 1'b0);
    chk("win_line2", win_cnt, 6);

    // hsync beats a same-cycle pixel; a second hsync does not rotate again
    step(1'b0, 1'b1, 1'b1);
    chk("drop_rd_addr", bus.rd_addr, 0);
    chk("drop_sel", bus.wr_sel, 3'b001);
    pixels(4);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("dbl_hsync_sel", bus.wr_sel, 3'b010);

    // 3-bit address wrap
    step(1'b1, 1'b0, 1'b0);
    pixels(7);
    chk("wrap_pre", bus3.rd_addr, 7);
    pixels(1);
    chk("wrap_zero", bus3.rd_addr, 0);
    pixels(1);
    chk("wrap_one", bus3.rd_addr, 1);
    step(1'b0, 1'b0, 1'b0);

    // 4x4 frame for the border flag
    step(1'b1, 1'b0, 1'b0);
    bd_cnt = 0;
    for (int l = 0; l < 4; l++) begin
      pixels(4);
      step(1'b0, 1'b1, 1'b0);
    end
`ifdef LINEBUF_SCHED_BORDER_EN
    chk("border_count", bd_cnt, 12);
`else
    chk("border_count", bd_cnt, 0);
`endif

    step(1'b0, 1'b0, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
